wb_serial_burst_tx: RTL and testbench
=====================================

# wb_serial_burst_tx

Wishbone classic slave that accepts configuration and payload writes from the system bus and transmits a burst of fixed-width serial frames on `data_o`, framed by the active-low burst strobe `ena_o`. It is the responder for the team's Wishbone write sequences and the source that the serial capture/checker logic samples.

## Interface

Parameters:
- FRAME_W, 10, bits per serial frame (payload width)
- RST_DIV, 1, reset value of CLK_DIV

Ports:
- CLK_I  in  1  system clock; all logic on rising edge
- RST_I  in  1  synchronous, active-high reset
- CYC_I  in  1  Wishbone bus cycle
- STB_I  in  1  Wishbone strobe
- WE_I  in  1  1 = write, 0 = read
- ADR_I  in  32  byte address; only ADR_I[3:2] decoded
- DAT_I  in  32  write data
- DAT_O  out  32  read data, valid while ACK_O = 1
- ACK_O  out  1  single-cycle acknowledge
- ena_o  out  1  burst strobe; 1 = idle, 0 = burst in progress
- data_o  out  1  serial data, LSB first

## Operation

- Register map (ADR_I[3:2]):
  - 0 CONFIG (RW): [7:0] CLK_DIV, so each bit lasts CLK_DIV+1 clocks; [15:8] NFRAMES, with 0 meaning 256; [16] START, write-only and read as 0; [31:17] reserved, read 0.
  - 1 SEED (RW): [FRAME_W-1:0] payload of the first frame.
  - 2 STATUS (RO): [0] BUSY; [15:8] frames remaining, including the current one; [16] DROP, sticky, cleared by any read of STATUS.
  - 3: reads 0, writes ignored, still acknowledged.
- Bus access:
  - A request is CYC_I & STB_I & !ACK_O, sampled on the clock edge.
  - ACK_O is asserted for exactly one cycle on the following cycle.
  - If STB_I is held, the next ACK comes at the earliest 2 cycles later, so there is never a back-to-back ACK.
  - Every address is acknowledged; there is no ERR or RTY.
  - Writes commit on the request edge. DAT_O is registered with ACK_O and is 0 when ACK_O = 0.
- Burst start:
  - Write to CONFIG with DAT_I[16] = 1 while idle: load CLK_DIV and NFRAMES, then start the burst.
  - Write to CONFIG with [16] = 0 while idle: update the registers only.
- Writes while BUSY:
  - Writes to CONFIG or SEED are acknowledged but discarded, and set DROP.
  - Reads work normally.
- Frame contents:
  - Frame k (k = 0..N-1) carries (SEED + k) mod 2^FRAME_W.
  - Bits go out LSB first, frames are back-to-back, and there are no start or stop bits.
- State machine:
  - IDLE: ena_o = 1, data_o = 0. Goes to SHIFT on a START write.
  - SHIFT: ena_o = 0. A bit-timer counts CLK_DIV..0, then the bit index advances. After bit FRAME_W-1 of the last frame has completed, go to IDLE.
  - Frame payload increment and frames-remaining decrement occur on the last clock of each frame.
- Reset: RST_I = 1 at any time, including mid-burst, aborts immediately.

## Timing

- Reset values:
  - ACK_O = 0, DAT_O = 0, ena_o = 1, data_o = 0, BUSY = 0, DROP = 0.
  - CLK_DIV = RST_DIV, NFRAMES = 1, SEED = 0.
- START write sampled at edge T:
  - ACK_O = 1 during cycle T+1.
  - ena_o falls at edge T+1, and data_o = SEED[0] from the same edge.
- Burst duration:
  - Bit j of frame k is stable for CLK_DIV+1 cycles starting at T+1 + (k·FRAME_W + j)·(CLK_DIV+1).
  - ena_o rises, and data_o returns to 0, exactly N·FRAME_W·(CLK_DIV+1) cycles after it fell.
  - BUSY clears on the same edge.
- Completion and restart:
  - A START write sampled on the edge where ena_o rises is treated as BUSY and dropped.
  - A START accepted one cycle later starts a new burst, so ena_o is high for a minimum of 1 cycle between bursts.
- CLK_DIV = 0 gives one bit per clock. CLK_DIV = 255 gives 256 clocks per bit.
- Payload wrap: with FRAME_W = 10 and SEED = 0x3FF, the next frame carries 0x000.
- Simultaneous RST_I and request: reset wins and no ACK is generated.

## Test plan

- **Reset values:** Hold RST_I for 200 cycles, then release. ACK_O = 0, DAT_O = 0, ena_o = 1, data_o = 0; a STATUS read returns 0x00000100 (BUSY = 0, 1 frame remaining).
- **Basic burst:** Write SEED = 0x005, then CONFIG = 0x30201 (CLK_DIV 1, 2 frames, START).
  - Exactly one ACK per write.
  - ena_o low for 40 cycles.
  - Sampling data_o every 2 cycles, LSB first, decodes 0x005 then 0x006.
- **Write while busy:** Mid-burst, write SEED = 0x123 and CONFIG = 0x10000.
  - Both writes are acknowledged.
  - The burst is unchanged.
  - A STATUS read returns DROP = 1; a second STATUS read returns DROP = 0.
  - A SEED read after the burst returns 0x005.
- **Held strobe:** Hold CYC_I/STB_I high on a read for 6 cycles. ACK_O pulses on cycles 2, 4 and 6, and is never high for two consecutive cycles.
- **Wrap and maximum count:** SEED = 0x3FF, CONFIG = 0x10000 (CLK_DIV 0, 256 frames).
  - The frames are 0x3FF, 0x000, 0x001, …, 0x0FE.
  - ena_o is low for 2560 cycles.
- **Reset mid-burst:** Assert RST_I for 1 cycle during frame 1 of a burst. On the next edge ena_o = 1 and data_o = 0, and all registers return to their reset values.

Source files
------------

// File: rtl/wb_serial_burst_tx_if.sv
// Wishbone classic bus bundle for the serial burst transmitter.
// The master modport drives requests; the slave modport returns data and acknowledge.
interface wb_serial_burst_tx_if;
   logic        CYC_I;
   logic        STB_I;
   logic        WE_I;
   logic [31:0] ADR_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
      input  DAT_O, ACK_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
      output DAT_O, ACK_O
   );
endinterface

// File: rtl/wb_serial_burst_tx.sv
// Wishbone classic slave that transmits a burst of FRAME_W-bit serial frames,
// LSB first, framed by the active-low strobe ena_o. Frame k carries SEED + k.
module wb_serial_burst_tx #(
   parameter int FRAME_W = 10,
   parameter int RST_DIV = 1
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   wb_serial_burst_tx_if.slave  wb,
   output logic                 ena_o,
   output logic                 data_o
);

   localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam logic [IDX_W-1:0]   LAST_BIT = IDX_W'(FRAME_W - 1);
   localparam logic [FRAME_W-1:0] PAY_ONE  = FRAME_W'(1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam logic [1:0] A_CONFIG = 2'd0;
   localparam logic [1:0] A_SEED   = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;

   logic [0:0]         state_reg;
   logic [7:0]         clk_div_reg;
   logic [7:0]         nframes_reg;
   logic [FRAME_W-1:0] seed_reg;
   logic               drop_reg;
   logic               ack_reg;
   logic [31:0]        dat_o_reg;
   logic [7:0]         bit_timer_reg;
   logic [IDX_W-1:0]   bit_idx_reg;
   logic [FRAME_W-1:0] payload_reg;
   logic [FRAME_W-1:0] shift_reg;
   logic [7:0]         frames_left_reg;

   logic        req;
   logic [1:0]  adr;
   logic        busy;
   logic        wr_cfg;
   logic        wr_seed;
   logic        start;
   logic [31:0] rdata;
   logic [FRAME_W-1:0] payload_next;

   // Address bits outside [3:2] and reserved data bits are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{wb.ADR_I[31:4], wb.ADR_I[1:0], wb.DAT_I[31:17]};

   // A new request is only taken when no acknowledge is pending, so held strobes never ACK back-to-back.
   assign req          = wb.CYC_I & wb.STB_I & ~ack_reg;
   assign adr          = wb.ADR_I[3:2];
   assign busy         = (state_reg == ST_SHIFT);
   assign wr_cfg       = req & wb.WE_I & (adr == A_CONFIG);
   assign wr_seed      = req & wb.WE_I & (adr == A_SEED);
   assign start        = wr_cfg & wb.DAT_I[16] & ~busy;
   assign payload_next = payload_reg + PAY_ONE;

   assign ena_o  = ~busy;
   assign data_o = busy & shift_reg[0];
   assign wb.ACK_O = ack_reg;
   assign wb.DAT_O = dat_o_reg;

   // Read multiplexer; START and reserved fields read back as zero.
   always_comb begin
      rdata = '0;
      case (adr)
         A_CONFIG: rdata[15:0] = {nframes_reg, clk_div_reg};
         A_SEED:   rdata[FRAME_W-1:0] = seed_reg;
         A_STATUS: begin
            rdata[0]    = busy;
            rdata[15:8] = frames_left_reg;
            rdata[16]   = drop_reg;
         end
         default:  rdata = '0;
      endcase
   end

   // Single-cycle acknowledge with read data registered alongside it.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ack_reg   <= 1'b0;
         dat_o_reg <= '0;
      end else begin
         ack_reg   <= req;
         dat_o_reg <= (req & ~wb.WE_I) ? rdata : '0;
      end
   end

   // Configuration registers are only writable while no burst is running.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         clk_div_reg <= 8'(RST_DIV);
         nframes_reg <= 8'd1;
         seed_reg    <= '0;
      end else if (!busy) begin
         if (wr_cfg) begin
            clk_div_reg <= wb.DAT_I[7:0];
            nframes_reg <= wb.DAT_I[15:8];
         end
         if (wr_seed) begin
            seed_reg <= wb.DAT_I[FRAME_W-1:0];
         end
      end
   end

   // Sticky DROP: set by discarded writes during a burst, cleared by a STATUS read.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         drop_reg <= 1'b0;
      end else if (busy && (wr_cfg || wr_seed)) begin
         drop_reg <= 1'b1;
      end else if (req && !wb.WE_I && adr == A_STATUS) begin
         drop_reg <= 1'b0;
      end
   end

   // Burst engine: per-bit timer, bit index within the frame, and frame counter.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_reg       <= ST_IDLE;
         bit_timer_reg   <= '0;
         bit_idx_reg     <= '0;
         payload_reg     <= '0;
         shift_reg       <= '0;
         frames_left_reg <= 8'd1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg       <= ST_SHIFT;
                  bit_timer_reg   <= wb.DAT_I[7:0];
                  bit_idx_reg     <= '0;
                  payload_reg     <= seed_reg;
                  shift_reg       <= seed_reg;
                  frames_left_reg <= wb.DAT_I[15:8];
               end else if (wr_cfg) begin
                  frames_left_reg <= wb.DAT_I[15:8];
               end
            end
            default: begin
               if (bit_timer_reg != 8'd0) begin
                  bit_timer_reg <= bit_timer_reg - 8'd1;
               end else begin
                  bit_timer_reg <= clk_div_reg;
                  if (bit_idx_reg == LAST_BIT) begin
                     bit_idx_reg     <= '0;
                     frames_left_reg <= frames_left_reg - 8'd1;
                     // A count of 1 means this was the final frame; 0 encodes 256.
                     if (frames_left_reg == 8'd1) begin
                        state_reg <= ST_IDLE;
                     end else begin
                        payload_reg <= payload_next;
                        shift_reg   <= payload_next;
                     end
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                     shift_reg   <= shift_reg >> 1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_serial_burst_tx.sv
// Randomized self-checking bench for wb_serial_burst_tx with a frame-level reference model.
module tb_wb_serial_burst_tx;

   localparam int FW = 10;
   localparam int RDIV = 1;
   localparam logic [31:0] MASK = (32'd1 << FW) - 32'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena;
   logic dat;

   wb_serial_burst_tx_if wb_if ();

   wb_serial_burst_tx #(.FRAME_W(FW), .RST_DIV(RDIV)) dut (
      .CLK_I  (clk),
      .RST_I  (rst),
      .wb     (wb_if),
      .ena_o  (ena),
      .data_o (dat)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   logic cap_q[$];
   int   done_count = 0;
   logic prev_low = 1'b0;
   int   cap_base;
   int   done_base;

   // Record data_o for every cycle the strobe is low; count completed bursts.
   always @(negedge clk) begin
      if (ena === 1'b0) cap_q.push_back(dat);
      if (ena === 1'b1 && prev_low) done_count <= done_count + 1;
      prev_low <= (ena === 1'b0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                          output logic [31:0] rdata);
      bit got_ack;
      got_ack = 1'b0;
      @(negedge clk);
      wb_if.CYC_I = 1'b1;
      wb_if.STB_I = 1'b1;
      wb_if.WE_I  = we;
      wb_if.ADR_I = {28'd0, idx, 2'b00};
      wb_if.DAT_I = wdata;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wb_if.ACK_O === 1'b1) begin
            got_ack = 1'b1;
            break;
         end
      end
      rdata = wb_if.DAT_O;
      wb_if.CYC_I = 1'b0;
      wb_if.STB_I = 1'b0;
      wb_if.WE_I  = 1'b0;
      if (!got_ack) chk("ack_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("ack_single", 32'(wb_if.ACK_O), 32'd0);
      chk("dat_o_idle", wb_if.DAT_O, 32'd0);
      $display("bus %s reg%0d wdata=0x%08h rdata=0x%08h", we ? "WR" : "RD", idx, wdata, rdata);
   endtask

   task automatic start_burst(input logic [31:0] seed, input logic [31:0] cfg);
      logic [31:0] rd;
      wb_xfer(1'b1, 2'd1, seed, rd);
      cap_base  = cap_q.size();
      done_base = done_count;
      wb_xfer(1'b1, 2'd0, cfg, rd);
      chk("ena_fell", 32'(ena), 32'd0);
   endtask

   // Reference model: bit j of frame k is ((seed+k) mod 2^FW) >> j, each held div+1 cycles.
   task automatic finish_burst(input logic [31:0] seed, input int div, input int nfr);
      int n, cycles, got_len, errs;
      logic [31:0] exp_frame, got_frame;
      logic exp_bit;
      n = (nfr == 0) ? 256 : nfr;
      cycles = n * FW * (div + 1);
      for (int i = 0; i < cycles + 100; i++) begin
         if (done_count != done_base) break;
         @(negedge clk);
      end
      if (done_count == done_base) chk("burst_timeout", 32'd0, 32'd1);
      got_len = cap_q.size() - cap_base;
      chk("burst_len", got_len, cycles);
      for (int k = 0; k < n; k++) begin
         exp_frame = (seed + k) & MASK;
         got_frame = '0;
         for (int j = 0; j < FW; j++) begin
            int idx;
            idx = cap_base + (k * FW + j) * (div + 1);
            if (idx < cap_q.size() && cap_q[idx] === 1'b1) got_frame[j] = 1'b1;
         end
         chk($sformatf("frame%0d", k), got_frame, exp_frame);
      end
      errs = 0;
      for (int c = 0; c < cycles; c++) begin
         int bp;
         bp = c / (div + 1);
         exp_frame = (seed + bp / FW) & MASK;
         exp_bit = exp_frame[bp % FW];
         if (cap_base + c >= cap_q.size() || cap_q[cap_base + c] !== exp_bit) errs++;
      end
      chk("stream_errs", errs, 0);
      chk("idle_ena", 32'(ena), 32'd1);
      chk("idle_data", 32'(dat), 32'd0);
      $display("burst seed=0x%03h div=%0d frames=%0d cycles=%0d", seed, div, n, got_len);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [5:0]  pat;
      logic [31:0] s;
      int d, n;

      wb_if.CYC_I = 1'b0;
      wb_if.STB_I = 1'b0;
      wb_if.WE_I  = 1'b0;
      wb_if.ADR_I = '0;
      wb_if.DAT_I = '0;

      // Reset values
      repeat (200) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", 32'(wb_if.ACK_O), 32'd0);
      chk("rst_dat", wb_if.DAT_O, 32'd0);
      chk("rst_ena", 32'(ena), 32'd1);
      chk("rst_data", 32'(dat), 32'd0);
      wb_xfer(1'b0, 2'd2, '0, rd); chk("rst_status", rd, 32'h0000_0100);
      wb_xfer(1'b0, 2'd0, '0, rd); chk("rst_config", rd, 32'h0000_0100 | RDIV);
      wb_xfer(1'b0, 2'd1, '0, rd); chk("rst_seed", rd, 32'd0);
      wb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, rd);
      wb_xfer(1'b0, 2'd3, '0, rd); chk("reg3_read", rd, 32'd0);

      // Basic burst with busy-time writes
      start_burst(32'h005, 32'h0003_0201);
      repeat (3) @(negedge clk);
      wb_xfer(1'b1, 2'd1, 32'h123, rd);
      wb_xfer(1'b1, 2'd0, 32'h0001_0000, rd);
      wb_xfer(1'b0, 2'd2, '0, rd); chk("drop_set", rd & 32'h0001_0001, 32'h0001_0001);
      wb_xfer(1'b0, 2'd2, '0, rd); chk("drop_clr", rd & 32'h0001_0001, 32'h0000_0001);
      finish_burst(32'h005, 1, 2);
      wb_xfer(1'b0, 2'd1, '0, rd); chk("seed_kept", rd, 32'h005);
      wb_xfer(1'b0, 2'd0, '0, rd); chk("cfg_kept", rd, 32'h0000_0201);

      // Held strobe on a read: ACK every other cycle
      @(negedge clk);
      wb_if.CYC_I = 1'b1;
      wb_if.STB_I = 1'b1;
      wb_if.WE_I  = 1'b0;
      wb_if.ADR_I = 32'h8;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[i] = wb_if.ACK_O;
      end
      wb_if.CYC_I = 1'b0;
      wb_if.STB_I = 1'b0;
      chk("held_ack", 32'(pat), 32'h15);
      @(negedge clk);

      // Idle CONFIG write without START updates registers only
      wb_xfer(1'b1, 2'd0, 32'h0000_0403, rd);
      chk("nostart_ena", 32'(ena), 32'd1);
      wb_xfer(1'b0, 2'd0, '0, rd); chk("nostart_cfg", rd, 32'h0000_0403);
      wb_xfer(1'b0, 2'd2, '0, rd); chk("nostart_busy", rd & 32'h0001_0001, 32'd0);

      // Payload wrap with 256 frames at one bit per clock
      start_burst(32'h3FF, 32'h0001_0000);
      finish_burst(32'h3FF, 0, 0);

      // Randomized bursts
      for (int it = 0; it < 6; it++) begin
         s = $urandom & MASK;
         d = $urandom_range(0, 3);
         n = $urandom_range(1, 5);
         start_burst(s, 32'h0001_0000 | (n << 8) | d);
         finish_burst(s, d, n);
      end

      // Reset during frame 1 aborts the burst and restores reset values
      s = $urandom & MASK;
      start_burst(s, 32'h0003_0201);
      repeat (25) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ena", 32'(ena), 32'd1);
      chk("abort_data", 32'(dat), 32'd0);
      rst = 1'b0;
      wb_xfer(1'b0, 2'd0, '0, rd); chk("abort_config", rd, 32'h0000_0100 | RDIV);
      wb_xfer(1'b0, 2'd1, '0, rd); chk("abort_seed", rd, 32'd0);
      wb_xfer(1'b0, 2'd2, '0, rd); chk("abort_status", rd, 32'h0000_0100);

      // Reset and request in the same cycle: reset wins, no ACK, no write
      @(negedge clk);
      rst = 1'b1;
      wb_if.CYC_I = 1'b1;
      wb_if.STB_I = 1'b1;
      wb_if.WE_I  = 1'b1;
      wb_if.ADR_I = 32'h4;
      wb_if.DAT_I = 32'h2AA;
      @(negedge clk);
      chk("rst_req_ack", 32'(wb_if.ACK_O), 32'd0);
      wb_if.CYC_I = 1'b0;
      wb_if.STB_I = 1'b0;
      wb_if.WE_I  = 1'b0;
      rst = 1'b0;
      wb_xfer(1'b0, 2'd1, '0, rd); chk("rst_req_seed", rd, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
